// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: bubble encoding, control-flow opcodes
// and the fetch FSM state encoding.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT_RSP,
        FS_HOLD,
        FS_DRAIN
    } fetch_state_e;

    // True for instructions that may redirect the PC.
    function automatic logic is_ctrl_flow(input logic [31:0] instr);
        return (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_JALR) ||
               (instr[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: sequential increment with 32-bit wrap and redirect mux.
// A redirect target is forced to word alignment.
module fetch_pc_gen
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic        advance,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] pc_seq
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc     = pc_q;
    assign pc_seq = pc_q + PC_STEP;

    // Redirect wins over the sequential step.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {br_target[31:2], 2'b00};
        end else if (advance) begin
            pc_d = pc_seq;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: instruction-memory handshake (one request in
// flight), IF/DE register, bubble insertion and redirect handling.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic        false_path,
    input  logic [31:0] br_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr_fetch,
    output logic [31:0] pc_fetch,
    output logic [31:0] pc_4_fetch,
    output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic         shown_q, shown_d;     // request presented, not yet accepted
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_fetch_q, pc_fetch_d;
    logic [31:0]  pc_4_q, pc_4_d;
    logic         valid_q, valid_d;
    logic         pc_adv;
    logic         load_en;
    logic [31:0]  load_data;
    logic [31:0]  pc;
    logic [31:0]  pc_seq;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .redirect  (pc_sel),
        .advance   (pc_adv),
        .br_target (br_target),
        .pc        (pc),
        .pc_seq    (pc_seq)
    );

    assign imem_req_addr = pc;
    assign instr_fetch   = instr_q;
    assign pc_fetch      = pc_fetch_q;
    assign pc_4_fetch    = pc_4_q;
    assign fetch_valid   = valid_q;

    // Next-state, handshake outputs and IF/DE load decision.
    always_comb begin
        state_d        = state_q;
        kill_d         = kill_q;
        hold_d         = hold_q;
        pc_adv         = 1'b0;
        load_en        = 1'b0;
        load_data      = hold_q;
        imem_req_valid = 1'b0;
        case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                // A stall only blocks a fresh request; once shown it stays up.
                imem_req_valid = !stall || shown_q;
                if (imem_req_valid && imem_req_ready) begin
                    if (pc_sel) begin
                        kill_d  = 1'b1;
                        state_d = FS_DRAIN;
                    end else begin
                        state_d = FS_WAIT_RSP;
                    end
                end
            end
            FS_WAIT_RSP: begin
                if (pc_sel) begin
                    if (imem_rsp_valid) begin
                        state_d = FS_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = FS_DRAIN;
                    end
                end else if (imem_rsp_valid) begin
                    if (stall || false_path) begin
                        hold_d  = imem_rsp_data;
                        state_d = FS_HOLD;
                    end else begin
                        load_en   = 1'b1;
                        load_data = imem_rsp_data;
                        pc_adv    = 1'b1;
                        state_d   = FS_REQ;
                    end
                end
            end
            FS_HOLD: begin
                if (pc_sel) begin
                    state_d = FS_REQ;
                end else if (!stall && !false_path) begin
                    load_en = 1'b1;
                    pc_adv  = 1'b1;
                    state_d = FS_REQ;
                end
            end
            FS_DRAIN: begin
                if (imem_rsp_valid && kill_q) begin
                    kill_d  = 1'b0;
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        shown_d = imem_req_valid && !imem_req_ready;
    end

    // IF/DE register: a wrong-path flush overrides any load.
    always_comb begin
        instr_d    = instr_q;
        pc_fetch_d = pc_fetch_q;
        pc_4_d     = pc_4_q;
        valid_d    = valid_q;
        if (false_path) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_en) begin
            instr_d    = load_data;
            pc_fetch_d = pc;
            pc_4_d     = pc_seq;
            valid_d    = 1'b1;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_IDLE;
            kill_q     <= 1'b0;
            shown_q    <= 1'b0;
            hold_q     <= 32'd0;
            instr_q    <= NOP_INSTR;
            pc_fetch_q <= 32'd0;
            pc_4_q     <= PC_STEP;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            shown_q    <= shown_d;
            hold_q     <= hold_d;
            instr_q    <= instr_d;
            pc_fetch_q <= pc_fetch_d;
            pc_4_q     <= pc_4_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;

    // Saturating event counters.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (pc_sel && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed steps followed by a randomized phase, all
// checked against a transaction-level reference model of the fetch stage.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, pc_sel, false_path;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr_fetch, pc_fetch, pc_4_fetch;
    logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    int          m_stall_cnt, m_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcf, m_pc4, m_pdata, o_addr;
    logic        m_valid, m_pend, outst, o_live, prev_unacc;
    int          o_lat, force_lat, delivered;

    fetch_ctrl #(.RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .false_path     (false_path),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_fetch    (instr_fetch),
        .pc_fetch       (pc_fetch),
        .pc_4_fetch     (pc_4_fetch),
        .fetch_valid    (fetch_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents as a function of address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h100; m_instr = NOP; m_pcf = 32'd0; m_pc4 = 32'd4;
        m_valid = 1'b0; m_pend = 1'b0; outst = 1'b0; o_live = 1'b0;
        prev_unacc = 1'b0; o_lat = 0;
`ifdef FETCH_PERF_CNT_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h100);
        chk({tag, "_instr"}, instr_fetch, NOP);
        chk({tag, "_pc_fetch"}, pc_fetch, 32'd0);
        chk({tag, "_pc_4"}, pc_4_fetch, 32'd4);
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    endtask

    // One clock: request-side checks before the edge, model update at the
    // edge, memory response driving and IF/DE checks after it.
    task automatic cycle();
        logic        rsp_now, acc, live;
        logic [31:0] acc_addr, tgt;
        #1;
        rsp_now  = imem_rsp_valid;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        live     = rsp_now && outst && o_live && !pc_sel;
        tgt      = {br_target[31:2], 2'b00};
        if (imem_req_valid === 1'b1) begin
            chk("req_addr", imem_req_addr, m_pc);
            chk("single_outstanding", {31'd0, outst}, 32'd0);
        end
        if (prev_unacc) chk("req_held", {31'd0, imem_req_valid}, 32'd1);
        prev_unacc = imem_req_valid && !imem_req_ready && !pc_sel;
        @(posedge clk);
`ifdef FETCH_PERF_CNT_EN
        if (stall) m_stall_cnt++;
        if (pc_sel) m_flush_cnt++;
`endif
        if (pc_sel) begin
            m_pc = tgt;
            m_pend = 1'b0;
            if (false_path) begin m_instr = NOP; m_valid = 1'b0; end
        end else begin
            if (false_path) begin m_instr = NOP; m_valid = 1'b0; end
            if (live) begin m_pend = 1'b1; m_pdata = mem_fn(o_addr); end
            if (m_pend && !stall && !false_path) begin
                m_instr = m_pdata; m_pcf = m_pc; m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = m_pc + 32'd4; m_pend = 1'b0;
                delivered++;
            end
        end
        if (rsp_now) outst = 1'b0;
        if (pc_sel) o_live = 1'b0;
        if (acc) begin
            outst  = 1'b1;
            o_addr = acc_addr;
            o_live = !pc_sel;
            o_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(3, 0));
        end
        #1;
        imem_rsp_valid = 1'b0;
        if (outst) begin
            if (o_lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_fn(o_addr);
            end else begin
                o_lat--;
            end
        end
        chk("instr_fetch", instr_fetch, m_instr);
        chk("pc_fetch", pc_fetch, m_pcf);
        chk("pc_4_fetch", pc_4_fetch, m_pc4);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
    endtask

    task automatic run_until_fetch(input logic [31:0] pc, input int max, input string tag);
        int n = 0;
        while (!(fetch_valid === 1'b1 && pc_fetch === pc) && n < max) begin
            cycle();
            n++;
        end
        chk(tag, pc_fetch, pc);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_sel = 1'b0; false_path = 1'b0;
        br_target = 32'd0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0; force_lat = 0; delivered = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Sequential fetch, ready=1, 1-cycle responses
        cycle();                                  // IDLE -> REQ
        cycle();                                  // request 0x100 accepted
        cycle();                                  // response loaded
        chk("seq0_pc", pc_fetch, 32'h100);
        chk("seq0_pc4", pc_4_fetch, 32'h104);
        chk("seq0_valid", {31'd0, fetch_valid}, 32'd1);
        chk("seq0_instr", instr_fetch, mem_fn(32'h100));
        cycle();
        cycle();
        chk("seq1_pc", pc_fetch, 32'h104);
        chk("seq1_pc4", pc_4_fetch, 32'h108);

        // Stall for 3 cycles while the response returns
        cycle();                                  // request 0x108 accepted
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold_pc", pc_fetch, 32'h104);
        end
        stall = 1'b0;
        cycle();
        chk("stall_release_pc", pc_fetch, 32'h108);
        chk("stall_release_instr", instr_fetch, mem_fn(32'h108));
        chk("no_dup_next_addr", imem_req_addr, 32'h10C);

        // Redirect while a response is outstanding
        force_lat = 2;
        cycle();                                  // 0x10C accepted, slow response
        pc_sel = 1'b1; br_target = 32'h200;
        cycle();
        pc_sel = 1'b0;
        cycle();
        cycle();                                  // killed response drained
        chk("redirect_addr", imem_req_addr, 32'h200);
        chk("redirect_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("killed_not_shown", pc_fetch, 32'h108);
        force_lat = 0;
        cycle();
        cycle();
        chk("redirect_fetch_pc", pc_fetch, 32'h200);

        // pc_sel, stall and false_path together; target low bits forced to 0
        pc_sel = 1'b1; stall = 1'b1; false_path = 1'b1; br_target = 32'h307;
        cycle();
        chk("combo_instr", instr_fetch, NOP);
        chk("combo_valid", {31'd0, fetch_valid}, 32'd0);
        pc_sel = 1'b0; stall = 1'b0; false_path = 1'b0;
        #1;
        chk("combo_addr", imem_req_addr, 32'h304);
        run_until_fetch(32'h304, 10, "combo_fetch_pc");

        // Redirect to the top word: PC wraps to 0
        pc_sel = 1'b1; br_target = 32'hFFFF_FFFC;
        cycle();
        pc_sel = 1'b0;
        run_until_fetch(32'hFFFF_FFFC, 12, "wrap_fetch_pc");
        chk("wrap_pc4", pc_4_fetch, 32'd0);
        chk("wrap_next_addr", imem_req_addr, 32'd0);

        // Randomized traffic
        force_lat = -1;
        delivered = 0;
        for (int i = 0; i < 600; i++) begin
            stall          = ($urandom_range(9, 0) < 3);
            imem_req_ready = ($urandom_range(2, 0) != 0);
            pc_sel         = ($urandom_range(19, 0) == 0);
            false_path     = pc_sel && $urandom_range(1, 0) == 1;
            br_target      = $urandom;
            cycle();
        end
        chk("random_progress", {31'd0, delivered > 20}, 32'd1);

        // Asynchronous reset in the middle of an outstanding fetch
        stall = 1'b0; pc_sel = 1'b0; false_path = 1'b0; imem_req_ready = 1'b1;
        force_lat = 3;
        for (int n = 0; n < 40 && !(outst && o_lat > 0); n++) cycle();
        chk("reach_wait_rsp", {31'd0, outst}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        imem_rsp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        force_lat = 0;
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;                    // stray response while IDLE
        imem_rsp_data  = 32'hBAD0_0BAD;
        cycle();
        chk("stray_ignored", instr_fetch, NOP);
        chk("restart_addr", imem_req_addr, 32'h100);
        run_until_fetch(32'h100, 10, "restart_fetch_pc");
        chk("restart_instr", instr_fetch, mem_fn(32'h100));

`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, m_stall_cnt);
        chk("perf_flush", perf_flush_cnt, m_flush_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
